operand_mux_pipe: RTL and testbench

Parametrised N-to-1 operand selector with a built-in, stallable and flushable pipeline register chain, for the pipelined CPU datapath. It replaces fixed-width combinational selectors on forwarding and ALU-source paths where the selected operand must also be registered into the next stage. It adds valid tracking, stall/flush control and detection of out-of-range selects.

---
 rtl/operand_mux_pipe.sv | 79 +++++++
 tb/tb_operand_mux_pipe.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_mux_pipe.sv
// operand_mux_pipe: N-to-1 operand selector feeding a stallable,
// flushable register chain with out-of-range select tracking.
module operand_mux_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int STAGES = 1,
  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_IN*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]        select_i,
  input  logic                    valid_i,
  input  logic                    stall_i,
  input  logic                    flush_i,
  output logic [WIDTH-1:0]        data_o,
  output logic                    valid_o,
  output logic                    sel_err_o,
  output logic [7:0]              err_cnt_o
);

  localparam logic [SEL_W:0] LP_NUM = NUM_IN[SEL_W:0];

  logic [WIDTH-1:0] w_sel_data;
  logic             w_oor;
  logic             w_err;

  logic             r_v [STAGES];
  logic [WIDTH-1:0] r_d [STAGES];
  logic             r_sel_err;
  logic [7:0]       r_err_cnt;

  // Unmatched (out-of-range) selects fall back to input 0.
  always_comb begin
    w_sel_data = data_i[WIDTH-1:0];
    for (int k = 1; k < NUM_IN; k++) begin
      if (select_i == k[SEL_W-1:0]) begin
        w_sel_data = data_i[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_oor = ({1'b0, select_i} >= LP_NUM);
  assign w_err = valid_i & w_oor;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int s = 0; s < STAGES; s++) begin
        r_v[s] <= 1'b0;
        r_d[s] <= '0;
      end
      r_sel_err <= 1'b0;
      r_err_cnt <= 8'd0;
    end else if (flush_i) begin
      for (int s = 0; s < STAGES; s++) begin
        r_v[s] <= 1'b0;
        r_d[s] <= '0;
      end
      r_sel_err <= 1'b0;
    end else if (!stall_i) begin
      r_v[0] <= valid_i;
      r_d[0] <= valid_i ? w_sel_data : '0;
      for (int s = 1; s < STAGES; s++) begin
        r_v[s] <= r_v[s-1];
        r_d[s] <= r_d[s-1];
      end
      r_sel_err <= w_err;
      if (w_err && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign data_o    = r_d[STAGES-1];
  assign valid_o   = r_v[STAGES-1];
  assign sel_err_o = r_sel_err;
  assign err_cnt_o = r_err_cnt;

endmodule

// File: tb/tb_operand_mux_pipe.sv
// tb_operand_mux_pipe: randomized and directed checks against
// a queue-based reference model of the operand pipeline.
module tb_operand_mux_pipe;

  localparam int W  = 32;
  localparam int N  = 3;
  localparam int ST = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  words [N];
  logic [N*W-1:0] data_i;
  logic [1:0]    sel = '0;
  logic          vld = 1'b0;
  logic          stl = 1'b0;
  logic          fls = 1'b0;
  logic [W-1:0]  data_o;
  logic          valid_o;
  logic          sel_err_o;
  logic [7:0]    err_cnt_o;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W:0] m_q [$];
  logic       m_err;
  int         m_cnt;

  assign data_i = {words[2], words[1], words[0]};

  always #5 clk = ~clk;

  operand_mux_pipe #(
    .WIDTH(W), .NUM_IN(N), .STAGES(ST)
  ) dut (
    .clk_i(clk), .rst_i(rst), .data_i(data_i),
    .select_i(sel), .valid_i(vld), .stall_i(stl),
    .flush_i(fls), .data_o(data_o), .valid_o(valid_o),
    .sel_err_o(sel_err_o), .err_cnt_o(err_cnt_o)
  );

  function automatic logic [W-1:0] ref_sel(input logic [1:0] s);
    return (int'(s) < N) ? words[s] : words[0];
  endfunction

  function automatic logic [41:0] got();
    return {valid_o, data_o, sel_err_o, err_cnt_o};
  endfunction

  function automatic logic [41:0] expv();
    return {m_q[0], m_err, m_cnt[7:0]};
  endfunction

  task automatic m_clear();
    m_q.delete();
    for (int i = 0; i < ST; i++) m_q.push_back('0);
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  // One clock edge: advance the model, then settle past the edge.
  task automatic tick();
    logic oor;
    @(posedge clk);
    if (fls) begin
      m_q.delete();
      for (int i = 0; i < ST; i++) m_q.push_back('0);
      m_err = 1'b0;
    end else if (!stl) begin
      oor = vld && (int'(sel) >= N);
      m_q.push_back({vld, vld ? ref_sel(sel) : {W{1'b0}}});
      void'(m_q.pop_front());
      m_err = oor;
      if (oor && m_cnt < 255) m_cnt++;
    end
    #1;
  endtask

  task automatic idle();
    vld = 1'b0; stl = 1'b0; fls = 1'b0; sel = '0;
  endtask

  task automatic set_words();
    words[0] = 32'h11111111;
    words[1] = 32'h22222222;
    words[2] = 32'h33333333;
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    #3;
    m_clear();
    @(posedge clk);
    #1;
    idle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      vld = 1'($urandom); sel = 2'($urandom);
      stl = 1'($urandom); fls = 1'($urandom);
      @(posedge clk);
      #1;
      n_cmp++;
      if (got() !== 42'h0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %h want 0", i, got());
      end
    end
    m_clear();
    idle();
    rst = 1'b1;
    vld = 1'b1; sel = 2'd2;
    tick();
    idle();
    n_cmp++;
    if (valid_o !== 1'b0 || got() !== expv()) begin
      n_fail++;
      $display("FAIL reset_edge1: got %h want %h", got(), expv());
    end
    tick();
    n_cmp++;
    if (got() !== expv() || data_o !== 32'h33333333 || !valid_o) begin
      n_fail++;
      $display("FAIL reset_first: got %h want %h", got(), expv());
    end
    tick();
    n_cmp++;
    if (got() !== expv()) begin
      n_fail++;
      $display("FAIL reset_drain: got %h want %h", got(), expv());
    end
  endtask

  task automatic test_stream();
    int nv;
    logic [W-1:0] seen [$];
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 3) begin
        vld = 1'b1; sel = 2'(i);
      end else begin
        idle();
      end
      tick();
      n_cmp++;
      if (got() !== expv()) begin
        n_fail++;
        $display("FAIL stream[%0d]: got %h want %h", i, got(), expv());
      end
      if (valid_o) begin
        nv++;
        seen.push_back(data_o);
      end
    end
    n_cmp++;
    if (nv != 3 || seen.size() != 3 || seen[0] !== 32'h11111111 ||
        seen[1] !== 32'h22222222 || seen[2] !== 32'h33333333) begin
      n_fail++;
      $display("FAIL stream_count: got %0d valid cycles want 3", nv);
    end
  endtask

  task automatic test_stall();
    vld = 1'b1; sel = 2'd1;
    tick();
    idle();
    stl = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (got() !== expv() || valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got %h want %h", i, got(), expv());
      end
    end
    stl = 1'b0;
    tick();
    n_cmp++;
    if (got() !== expv() || data_o !== 32'h22222222 || !valid_o) begin
      n_fail++;
      $display("FAIL stall_release: got %h want %h", got(), expv());
    end
    tick();
  endtask

  task automatic test_flush();
    vld = 1'b1; sel = 2'd2;
    tick();
    sel = 2'd1;
    tick();
    idle();
    fls = 1'b1; stl = 1'b1;
    tick();
    idle();
    n_cmp++;
    if (got() !== expv() || valid_o !== 1'b0 || data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL flush: got %h want %h", got(), expv());
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (got() !== expv() || valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_after[%0d]: got %h want %h", i, got(), expv());
      end
    end
  endtask

  task automatic test_oor();
    do_reset();
    vld = 1'b1; sel = 2'd3;
    tick();
    idle();
    n_cmp++;
    if (got() !== expv() || sel_err_o !== 1'b1 || err_cnt_o !== 8'd1) begin
      n_fail++;
      $display("FAIL oor_first: got %h want %h", got(), expv());
    end
    tick();
    n_cmp++;
    if (got() !== expv() || data_o !== 32'h11111111 || sel_err_o) begin
      n_fail++;
      $display("FAIL oor_data: got %h want %h", got(), expv());
    end
    vld = 1'b1; sel = 2'd3;
    for (int i = 0; i < 300; i++) begin
      tick();
      n_cmp++;
      if (got() !== expv() || sel_err_o !== 1'b1) begin
        n_fail++;
        $display("FAIL oor_run[%0d]: got %h want %h", i, got(), expv());
      end
    end
    n_cmp++;
    if (err_cnt_o !== 8'd255) begin
      n_fail++;
      $display("FAIL oor_sat: got %0d want 255", err_cnt_o);
    end
    vld = 1'b0;
    tick();
    idle();
    n_cmp++;
    if (got() !== expv() || err_cnt_o !== 8'd255 || sel_err_o) begin
      n_fail++;
      $display("FAIL oor_novalid: got %h want %h", got(), expv());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    vld = 1'b1; sel = 2'd3;
    repeat (5) tick();
    sel = 2'd1;
    repeat (2) tick();
    n_cmp++;
    if (got() !== expv() || !valid_o || err_cnt_o !== 8'd5) begin
      n_fail++;
      $display("FAIL async_pre: got %h want %h", got(), expv());
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (got() !== 42'h0) begin
      n_fail++;
      $display("FAIL async_reset: got %h want 0", got());
    end
    m_clear();
    @(posedge clk);
    #1;
    idle();
    rst = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) words[k] = $urandom;
      vld = 1'($urandom);
      sel = 2'($urandom);
      stl = ($urandom_range(0, 7) == 0);
      fls = ($urandom_range(0, 15) == 0);
      tick();
      n_cmp++;
      if (got() !== expv()) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h want %h", i, got(), expv());
      end
    end
    idle();
    set_words();
  endtask

  initial begin
    set_words();
    m_clear();
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_oor();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
